// File: rtl/game_ctrl_if.sv
// Signal bundle between the game controller and its surroundings (buttons, board flags, board commands).
// The controller uses the slave view; the board/button side uses the master view.
interface game_ctrl_if;
  logic        piece_clk;
  logic        start;
  logic        btn_left;
  logic        btn_right;
  logic        btn_rot_r;
  logic        btn_rot_l;
  logic        btn_drop;
  logic        can_fall;
  logic        can_left;
  logic        can_right;
  logic        spawn_blocked;
  logic [2:0]  state;
  logic [1:0]  rotate;
  logic        drop;
  logic        piece_req;
  logic [15:0] piece_count;

  modport master (
    output piece_clk, start, btn_left, btn_right, btn_rot_r, btn_rot_l, btn_drop,
    output can_fall, can_left, can_right, spawn_blocked,
    input  state, rotate, drop, piece_req, piece_count
  );

  modport slave (
    input  piece_clk, start, btn_left, btn_right, btn_rot_r, btn_rot_l, btn_drop,
    input  can_fall, can_left, can_right, spawn_blocked,
    output state, rotate, drop, piece_req, piece_count
  );
endinterface

// File: rtl/game_ctrl.sv
// Falling-block game controller: turns button edges and gravity ticks into one-cycle board commands
// and tracks the number of pieces locked since the game started.
module game_ctrl #(
  parameter int GRAVITY_TICKS = 30
) (
  input logic        clk,
  input logic        reset,
  game_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    NEW_PIECE    = 3'd1,
    FALL         = 3'd2,
    MOVEL        = 3'd3,
    MOVER        = 3'd4,
    PIECE_PLACED = 3'd5,
    LOSS         = 3'd6,
    WAIT         = 3'd7
  } state_t;

  localparam logic [7:0] GRAV_LAST = 8'(GRAVITY_TICKS - 1);

  state_t      state_q, state_d;
  logic [5:0]  btn_q, btn_now, btn_edge;
  logic        drop_q, drop_d;
  logic        pend_q, pend_d;
  logic [7:0]  grav_q, grav_d;
  logic [15:0] count_q, count_d;
  logic [1:0]  rotate_d;
  logic        grav_wrap, grav_evt, move_l, move_r;
  logic        start_e, left_e, right_e, rot_r_e, rot_l_e, drop_e;

  assign btn_now  = {bus.start, bus.btn_left, bus.btn_right, bus.btn_rot_r, bus.btn_rot_l, bus.btn_drop};
  assign btn_edge = btn_now & ~btn_q;
  assign {start_e, left_e, right_e, rot_r_e, rot_l_e, drop_e} = btn_edge;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      btn_q   <= '0;
      drop_q  <= 1'b0;
      pend_q  <= 1'b0;
      grav_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      btn_q   <= btn_now;
      drop_q  <= drop_d;
      pend_q  <= pend_d;
      grav_q  <= grav_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    drop_d    = drop_q;
    pend_d    = pend_q;
    grav_d    = grav_q;
    count_d   = count_q;
    rotate_d  = 2'b00;
    grav_wrap = 1'b0;
    grav_evt  = 1'b0;
    move_l    = 1'b0;
    move_r    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_e) begin
          state_d = NEW_PIECE;
          count_d = '0;
        end
      end

      NEW_PIECE: begin
        grav_d  = '0;
        pend_d  = 1'b0;
        drop_d  = 1'b0;
        state_d = bus.spawn_blocked ? LOSS : WAIT;
      end

      WAIT: begin
        // An active hard drop owns the piece; gravity and buttons are frozen until it lands.
        if (drop_q) begin
          state_d = bus.can_fall ? FALL : PIECE_PLACED;
        end else begin
          grav_wrap = bus.piece_clk && (grav_q == GRAV_LAST);
          if (bus.piece_clk) grav_d = grav_wrap ? 8'd0 : grav_q + 8'd1;
          grav_evt = pend_q | grav_wrap;
          move_l   = left_e & ~right_e & bus.can_left;
          move_r   = right_e & ~left_e & bus.can_right;
          pend_d   = 1'b0;
          // A gravity step that loses arbitration is remembered for the next WAIT cycle.
          if (drop_e) begin
            drop_d = 1'b1;
            pend_d = grav_evt;
          end else if (move_l) begin
            state_d = MOVEL;
            pend_d  = grav_evt;
          end else if (move_r) begin
            state_d = MOVER;
            pend_d  = grav_evt;
          end else if (grav_evt) begin
            state_d = bus.can_fall ? FALL : PIECE_PLACED;
          end else if (rot_r_e ^ rot_l_e) begin
            rotate_d = {rot_l_e, rot_r_e};
          end
        end
      end

      FALL, MOVEL, MOVER: state_d = WAIT;

      PIECE_PLACED: begin
        count_d = count_q + 16'd1;
        drop_d  = 1'b0;
        state_d = NEW_PIECE;
      end

      LOSS: begin
        if (start_e) begin
          count_d = '0;
          state_d = NEW_PIECE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.state       = state_q;
  assign bus.rotate      = rotate_d;
  assign bus.drop        = drop_q;
  assign bus.piece_req   = (state_q == NEW_PIECE);
  assign bus.piece_count = count_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed vector table, multi-cycle sequences, then random stimulus
// compared against a cycle-level behavioural model of the game rules.
module tb_game_ctrl;

  localparam int G = 3;

  localparam int S_IDLE = 0, S_NEW = 1, S_FALL = 2, S_MOVEL = 3, S_MOVER = 4,
                 S_PLACED = 5, S_LOSS = 6, S_WAIT = 7;

  typedef struct packed {
    logic reset, start, piece_clk, left, right, rot_r, rot_l, drop, can_fall, can_left, can_right, spawn;
  } in_t;

  localparam logic [11:0] I_RESET = 12'h800, I_START = 12'h400, I_PCLK = 12'h200, I_LEFT = 12'h100,
                          I_RIGHT = 12'h080, I_ROTR = 12'h040, I_ROTL = 12'h020, I_DROP = 12'h010,
                          I_CANF = 12'h008, I_CANL = 12'h004, I_CANR = 12'h002, I_SPAWN = 12'h001;

  typedef struct {
    logic [11:0] in;
    int          st;
    logic [1:0]  rot;
    logic        drp;
    logic        req;
    int          cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  in_t  cur;

  int   m_state, m_cnt, m_count;
  bit   m_pend, m_drop;
  in_t  m_prev;

  game_ctrl_if bus ();

  game_ctrl #(.GRAVITY_TICKS(G)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model of the game rules, advanced once per rising edge.
  function automatic logic [1:0] model_rotate(input in_t i);
    in_t e;
    bit  grav;
    e = in_t'(i & ~m_prev);
    if (m_state != S_WAIT || m_drop || e.drop) return 2'b00;
    grav = m_pend || (i.piece_clk && (m_cnt + 1 == G));
    if ((e.left && !e.right && i.can_left) || (e.right && !e.left && i.can_right) || grav) return 2'b00;
    if (e.rot_r && !e.rot_l) return 2'b01;
    if (e.rot_l && !e.rot_r) return 2'b10;
    return 2'b00;
  endfunction

  function automatic void model_step(input in_t i);
    in_t e;
    bit  wrap, grav, ml, mr;
    e = in_t'(i & ~m_prev);
    if (i.reset) begin
      m_state = S_IDLE; m_cnt = 0; m_pend = 0; m_drop = 0; m_count = 0; m_prev = '0;
      return;
    end
    m_prev = i;
    case (m_state)
      S_IDLE: if (e.start) begin m_state = S_NEW; m_count = 0; end
      S_NEW: begin
        m_cnt = 0; m_pend = 0; m_drop = 0;
        m_state = i.spawn ? S_LOSS : S_WAIT;
      end
      S_WAIT: begin
        if (m_drop) m_state = i.can_fall ? S_FALL : S_PLACED;
        else begin
          wrap = i.piece_clk && (m_cnt + 1 == G);
          if (i.piece_clk) m_cnt = (m_cnt + 1) % G;
          grav = m_pend || wrap;
          ml = e.left && !e.right && i.can_left;
          mr = e.right && !e.left && i.can_right;
          if (e.drop) begin m_drop = 1; m_pend = grav; end
          else if (ml) begin m_state = S_MOVEL; m_pend = grav; end
          else if (mr) begin m_state = S_MOVER; m_pend = grav; end
          else begin
            m_pend = 0;
            if (grav) m_state = i.can_fall ? S_FALL : S_PLACED;
          end
        end
      end
      S_FALL, S_MOVEL, S_MOVER: m_state = S_WAIT;
      S_PLACED: begin m_count = (m_count + 1) % 65536; m_drop = 0; m_state = S_NEW; end
      S_LOSS: if (e.start) begin m_count = 0; m_state = S_NEW; end
      default: m_state = S_IDLE;
    endcase
  endfunction

  task automatic applyStimulus(input in_t i);
    cur               = i;
    rst               = i.reset;
    bus.start         = i.start;
    bus.piece_clk     = i.piece_clk;
    bus.btn_left      = i.left;
    bus.btn_right     = i.right;
    bus.btn_rot_r     = i.rot_r;
    bus.btn_rot_l     = i.rot_l;
    bus.btn_drop      = i.drop;
    bus.can_fall      = i.can_fall;
    bus.can_left      = i.can_left;
    bus.can_right     = i.can_right;
    bus.spawn_blocked = i.spawn;
  endtask

  task automatic checkOutput(input string name, input int st, input logic [1:0] rot,
                             input logic drp, input logic req, input int cnt);
    @(negedge clk);
    total++;
    if (bus.state !== 3'(st) || bus.rotate !== rot || bus.drop !== drp ||
        bus.piece_req !== req || bus.piece_count !== 16'(cnt)) begin
      bad++;
      $display("[TB] FAIL %s: got state=%0d rotate=%b drop=%b req=%b count=%0d, want state=%0d rotate=%b drop=%b req=%b count=%0d",
               name, bus.state, bus.rotate, bus.drop, bus.piece_req, bus.piece_count, st, rot, drp, req, cnt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(cur);
    #1;
  endtask

  task automatic step(input logic [11:0] i, input string name, input int st, input logic [1:0] rot,
                      input logic drp, input logic req, input int cnt);
    applyStimulus(in_t'(i));
    checkOutput(name, st, rot, drp, req, cnt);
    tick();
  endtask

  vec_t vecs[22];
  int   drop_st[10];

  initial begin
    vecs[0]  = '{12'h000,          S_IDLE,  2'b00, 0, 0, 0};
    vecs[1]  = '{I_START,          S_IDLE,  2'b00, 0, 0, 0};
    vecs[2]  = '{I_START,          S_NEW,   2'b00, 0, 1, 0};
    vecs[3]  = '{12'h000,          S_WAIT,  2'b00, 0, 0, 0};
    vecs[4]  = '{I_LEFT | I_CANL,  S_WAIT,  2'b00, 0, 0, 0};
    vecs[5]  = '{I_LEFT | I_CANL,  S_MOVEL, 2'b00, 0, 0, 0};
    vecs[6]  = '{I_LEFT | I_CANL,  S_WAIT,  2'b00, 0, 0, 0};
    vecs[7]  = '{I_LEFT | I_CANL,  S_WAIT,  2'b00, 0, 0, 0};
    vecs[8]  = '{12'h000,          S_WAIT,  2'b00, 0, 0, 0};
    vecs[9]  = '{I_LEFT | I_RIGHT | I_CANL | I_CANR, S_WAIT, 2'b00, 0, 0, 0};
    vecs[10] = '{12'h000,          S_WAIT,  2'b00, 0, 0, 0};
    vecs[11] = '{I_RIGHT,          S_WAIT,  2'b00, 0, 0, 0};
    vecs[12] = '{12'h000,          S_WAIT,  2'b00, 0, 0, 0};
    vecs[13] = '{I_ROTR,           S_WAIT,  2'b01, 0, 0, 0};
    vecs[14] = '{I_ROTR,           S_WAIT,  2'b00, 0, 0, 0};
    vecs[15] = '{I_ROTL,           S_WAIT,  2'b10, 0, 0, 0};
    vecs[16] = '{12'h000,          S_WAIT,  2'b00, 0, 0, 0};
    vecs[17] = '{I_ROTR | I_ROTL,  S_WAIT,  2'b00, 0, 0, 0};
    vecs[18] = '{12'h000,          S_WAIT,  2'b00, 0, 0, 0};
    vecs[19] = '{I_RIGHT | I_CANR, S_WAIT,  2'b00, 0, 0, 0};
    vecs[20] = '{I_RIGHT | I_CANR, S_MOVER, 2'b00, 0, 0, 0};
    vecs[21] = '{12'h000,          S_WAIT,  2'b00, 0, 0, 0};
    drop_st  = '{S_WAIT, S_FALL, S_WAIT, S_FALL, S_WAIT, S_FALL, S_WAIT, S_PLACED, S_NEW, S_WAIT};

    applyStimulus(in_t'(I_RESET));
    tick();
    tick();

    foreach (vecs[k])
      step(vecs[k].in, $sformatf("vec%0d", k), vecs[k].st, vecs[k].rot, vecs[k].drp, vecs[k].req, vecs[k].cnt);

    // Gravity: a FALL on the cycle after every third piece_clk pulse.
    for (int p = 0; p < 9; p++)
      for (int k = 0; k < 4; k++)
        step((k == 0) ? (I_PCLK | I_CANF) : I_CANF, $sformatf("grav%0d_%0d", p, k),
             (p % 3 == 2 && k == 1) ? S_FALL : S_WAIT, 2'b00, 0, 0, 0);

    // Gravity with the floor reached locks the piece and requests the next one.
    for (int k = 0; k < 12; k++)
      step((k % 4 == 0) ? I_PCLK : 12'h000, $sformatf("lock%0d", k),
           (k == 9) ? S_PLACED : (k == 10) ? S_NEW : S_WAIT, 2'b00, 0, (k == 10), (k >= 10) ? 1 : 0);

    // Hard drop: three falls then a lock.
    step(I_DROP | I_CANF, "drop_edge", S_WAIT, 2'b00, 0, 0, 1);
    for (int k = 0; k < 10; k++)
      step((k < 6) ? (I_DROP | I_CANF) : I_DROP, $sformatf("drop%0d", k), drop_st[k], 2'b00,
           (k <= 7), (k == 8), (k >= 8) ? 2 : 1);
    step(12'h000, "drop_release", S_WAIT, 2'b00, 0, 0, 2);

    // Blocked spawn ends the game until start is pressed again.
    step(I_DROP, "loss_a", S_WAIT, 2'b00, 0, 0, 2);
    step(I_DROP, "loss_b", S_WAIT, 2'b00, 1, 0, 2);
    step(I_DROP, "loss_c", S_PLACED, 2'b00, 1, 0, 2);
    step(I_DROP | I_SPAWN, "loss_d", S_NEW, 2'b00, 0, 1, 3);
    for (int k = 0; k < 4; k++)
      step(12'h000, $sformatf("loss_hold%0d", k), S_LOSS, 2'b00, 0, 0, 3);
    step(I_START, "loss_start", S_LOSS, 2'b00, 0, 0, 3);
    step(I_START, "restart", S_NEW, 2'b00, 0, 1, 0);
    step(12'h000, "restart_wait", S_WAIT, 2'b00, 0, 0, 0);

    // Reset landing in a FALL cycle of a hard drop.
    step(I_DROP | I_CANF, "rst_a", S_WAIT, 2'b00, 0, 0, 0);
    step(I_DROP | I_CANF, "rst_b", S_WAIT, 2'b00, 1, 0, 0);
    step(I_RESET | I_DROP | I_CANF, "rst_fall", S_FALL, 2'b00, 1, 0, 0);
    step(I_DROP | I_CANF, "rst_after", S_IDLE, 2'b00, 0, 0, 0);

    applyStimulus(in_t'(I_RESET));
    tick();
    for (int n = 0; n < 4000; n++) begin
      in_t r;
      r           = '0;
      r.reset     = ($urandom_range(0, 299) == 0);
      r.start     = ($urandom_range(0, 39) == 0);
      r.piece_clk = ($urandom_range(0, 3) == 0);
      r.left      = ($urandom_range(0, 2) == 0);
      r.right     = ($urandom_range(0, 2) == 0);
      r.rot_r     = ($urandom_range(0, 2) == 0);
      r.rot_l     = ($urandom_range(0, 2) == 0);
      r.drop      = ($urandom_range(0, 11) == 0);
      r.can_fall  = ($urandom_range(0, 3) != 0);
      r.can_left  = $urandom_range(0, 1) == 1;
      r.can_right = $urandom_range(0, 1) == 1;
      r.spawn     = ($urandom_range(0, 9) == 0);
      applyStimulus(r);
      checkOutput($sformatf("rand%0d", n), m_state, model_rotate(r), m_drop, (m_state == S_NEW), m_count);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter GRAVITY_TICKS, default 30: number of piece_clk pulses per gravity step; legal range 1..255.
REQ-002 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port piece_clk  input  1  one-clk-cycle gravity tick pulse.
REQ-005 Port start  input  1  start/restart button, level.
REQ-006 Port btn_left, btn_right  input  1 each  move buttons, level.
REQ-007 Port btn_rot_r, btn_rot_l  input  1 each  rotate buttons, level.
REQ-008 Port btn_drop  input  1  hard-drop button, level.
REQ-009 Port can_fall, can_left, can_right  input  1 each  combinational legality flags from the board for the current piece.
REQ-010 Port spawn_blocked  input  1  spawn region occupied.
REQ-011 Port state  output  3  board command: IDLE=0, NEW_PIECE=1, FALL=2, MOVEL=3, MOVER=4, PIECE_PLACED=5, LOSS=6, WAIT=7.
REQ-012 Port rotate  output  2  rotate pulse: bit0 right, bit1 left.
REQ-013 Port drop  output  1  hard drop in progress.
REQ-014 Port piece_req  output  1  one-cycle pulse requesting the next piece from the generator.
REQ-015 Port piece_count  output  16  pieces locked since game start; wraps 0xFFFF->0.

Function
REQ-016 Button inputs SHALL be edge-detected against a registered copy; only a 0->1 edge is an event; a held button SHALL produce one event.
REQ-017 Each command state (NEW_PIECE, FALL, MOVEL, MOVER, PIECE_PLACED) SHALL last exactly one clk cycle.
REQ-018 IDLE: start edge -> NEW_PIECE; all other inputs ignored.
REQ-019 NEW_PIECE: piece_req=1 this cycle; gravity counter cleared; drop cleared; next = LOSS if spawn_blocked sampled this cycle, else WAIT.
REQ-020 WAIT priority per cycle, highest first: drop active, drop edge, left/right edge, gravity event, rotate edge.
REQ-021 Drop active in WAIT: next = FALL if can_fall else PIECE_PLACED; buttons and gravity counter ignored/held.
REQ-022 Drop edge in WAIT: drop set to 1 next cycle; state stays WAIT that cycle.
REQ-023 Left edge with can_left=1 -> MOVEL; right edge with can_right=1 -> MOVER; blocked move events SHALL be discarded, not queued.
REQ-024 Simultaneous left and right edges SHALL both be discarded.
REQ-025 Gravity counter (8-bit) SHALL increment on piece_clk in WAIT; at GRAVITY_TICKS-1 with piece_clk it wraps to 0 and raises a gravity event.
REQ-026 Gravity event: can_fall=1 -> FALL, else PIECE_PLACED.
REQ-027 A gravity event coinciding with an accepted move SHALL be retained and acted on in the next WAIT cycle.
REQ-028 rotate SHALL pulse 2'b01/2'b10 for one cycle only in WAIT cycles that issue no command and have drop=0; simultaneous rotate edges -> 2'b00.
REQ-029 FALL, MOVEL, MOVER -> WAIT.
REQ-030 PIECE_PLACED: piece_count +1; drop cleared; next NEW_PIECE.
REQ-031 LOSS: held until start edge; then piece_count=0 and next NEW_PIECE.
REQ-032 rotate=0 and piece_req=0 in every state except as stated above.

Reset
REQ-033 With reset=1 at a clk edge: state=IDLE, rotate=0, drop=0, piece_req=0, piece_count=0, gravity counter=0, pending gravity=0, edge registers=0.
REQ-034 Reset SHALL override all other inputs in any state, including mid-drop and command cycles.

Verification
REQ-035 reset, start pulse, spawn_blocked=0 -> IDLE, NEW_PIECE with piece_req=1 one cycle, then WAIT.
REQ-036 GRAVITY_TICKS=3, can_fall=1, piece_clk every 4 cycles -> exactly one FALL cycle every third pulse; can_fall=0 -> PIECE_PLACED, NEW_PIECE, piece_count=1.
REQ-037 btn_left held 10 cycles, can_left=1 -> one MOVEL cycle only; left+right same cycle -> no move; can_right=0 -> no MOVER.
REQ-038 Drop edge with can_fall=1 for 3 cycles then 0 -> drop=1, WAIT,FALL alternating x3, then PIECE_PLACED, drop=0.
REQ-039 spawn_blocked=1 during NEW_PIECE -> LOSS held; start edge -> NEW_PIECE, piece_count=0.
REQ-040 reset asserted during a FALL cycle with drop=1 -> next cycle IDLE, all outputs at reset values.
